fifo_block_reader: RTL and testbench

//  Drains the byte-wide packet FIFO (show-ahead: r_data valid whenever !empty, pop on r_enable)
//  and assembles BLOCKBYTES-byte blocks for the AES datapath. Sits between the packet FIFO

---
 rtl/fifo_block_reader.sv | 92 +++++++++
 tb/tb_fifo_block_reader.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_block_reader.sv
// Drains a show-ahead byte FIFO and assembles fixed-size blocks for the AES core.
// A flushed partial block is completed with PAD_BYTE and marked with block_last.
module fifo_block_reader #(
   parameter int                  NUMBITS    = 8,
   parameter int                  BLOCKBYTES = 16,
   parameter int                  CNTBITS    = 5,
   parameter logic [NUMBITS-1:0]  PAD_BYTE   = '0
) (
   input  logic                            clk,
   input  logic                            n_rst,
   input  logic                            fifo_empty,
   input  logic [NUMBITS-1:0]              fifo_r_data,
   output logic                            fifo_r_enable,
   input  logic                            flush,
   input  logic                            block_ready,
   output logic                            block_valid,
   output logic [NUMBITS*BLOCKBYTES-1:0]   block_data,
   output logic                            block_last,
   output logic [CNTBITS-1:0]              bytes_held
);

   localparam int              DW       = NUMBITS * BLOCKBYTES;
   localparam logic [CNTBITS-1:0] LAST_IDX = CNTBITS'(BLOCKBYTES - 1);
   localparam logic [CNTBITS-1:0] FULL_CNT = CNTBITS'(BLOCKBYTES);

   typedef enum logic [1:0] {FILL, PAD, PRESENT} state_t;

   state_t state;
   logic   flush_pend;

   assign fifo_r_enable = (state == FILL) && !fifo_empty;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state       <= FILL;
         flush_pend  <= 1'b0;
         block_valid <= 1'b0;
         block_data  <= '0;
         block_last  <= 1'b0;
         bytes_held  <= '0;
      end else begin
         case (state)
            FILL: begin
               if (fifo_r_enable) begin
                  block_data <= {block_data[DW-NUMBITS-1:0], fifo_r_data};
                  if (bytes_held == LAST_IDX) begin
                     // A flush coinciding with the final pop is absorbed by this block.
                     state       <= PRESENT;
                     bytes_held  <= FULL_CNT;
                     block_valid <= 1'b1;
                     block_last  <= 1'b0;
                     flush_pend  <= 1'b0;
                  end else begin
                     bytes_held  <= bytes_held + CNTBITS'(1);
                     flush_pend  <= flush_pend | flush;
                  end
               end else if (flush_pend && bytes_held != '0) begin
                  state      <= PAD;
                  flush_pend <= 1'b1;
               end else begin
                  // Pending flush on an empty block is dropped: no empty blocks.
                  flush_pend <= flush;
               end
            end
            PAD: begin
               block_data <= {block_data[DW-NUMBITS-1:0], PAD_BYTE};
               if (bytes_held == LAST_IDX) begin
                  state       <= PRESENT;
                  bytes_held  <= FULL_CNT;
                  block_valid <= 1'b1;
                  block_last  <= 1'b1;
                  flush_pend  <= flush;
               end else begin
                  bytes_held  <= bytes_held + CNTBITS'(1);
                  flush_pend  <= flush_pend | flush;
               end
            end
            PRESENT: begin
               flush_pend <= flush_pend | flush;
               if (block_ready) begin
                  state       <= FILL;
                  block_valid <= 1'b0;
                  block_last  <= 1'b0;
                  bytes_held  <= '0;
               end
            end
            default: state <= FILL;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_block_reader.sv
// Directed bench for fifo_block_reader: queue-based FIFO and block model, checked every cycle,
// plus literal expectations for the documented scenarios.
module tb_fifo_block_reader;

   logic         clk = 1'b0;
   logic         n_rst = 1'b0;
   logic         fifo_empty = 1'b1;
   logic [7:0]   fifo_r_data = 8'h00;
   logic         fifo_r_enable;
   logic         flush = 1'b0;
   logic         block_ready = 1'b0;
   logic         block_valid;
   logic [127:0] block_data;
   logic         block_last;
   logic [4:0]   bytes_held;

   fifo_block_reader dut (
      .clk(clk), .n_rst(n_rst), .fifo_empty(fifo_empty), .fifo_r_data(fifo_r_data),
      .fifo_r_enable(fifo_r_enable), .flush(flush), .block_ready(block_ready),
      .block_valid(block_valid), .block_data(block_data), .block_last(block_last),
      .bytes_held(bytes_held)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endfunction

   // Bench-side FIFO
   logic [7:0] fq[$];

   function automatic void fifo_refresh();
      fifo_empty  = (fq.size() == 0);
      fifo_r_data = (fq.size() == 0) ? 8'h00 : fq[0];
   endfunction

   task automatic push(input logic [7:0] b);
      fq.push_back(b);
      fifo_refresh();
   endtask

   // Block model: bytes gathered so far, presented block, flush bookkeeping
   logic [7:0]   m_part[$];
   bit           m_pres = 0, m_pad = 0, m_pend = 0, m_last = 0;
   logic [127:0] m_blk = '0;

   function automatic void close_block(bit last, bit pend);
      logic [127:0] r;
      r = '0;
      foreach (m_part[i]) r = {r[119:0], m_part[i]};
      m_blk  = r;
      m_pres = 1;
      m_last = last;
      m_pend = pend;
      m_pad  = 0;
      m_part.delete();
   endfunction

   function automatic void model_update(bit fl, bit rdy, bit popped, logic [7:0] head);
      if (!n_rst) begin
         m_part.delete();
         m_pres = 0; m_pad = 0; m_pend = 0; m_last = 0; m_blk = '0;
      end else if (m_pres) begin
         m_pend |= fl;
         if (rdy) begin
            m_pres = 0;
            m_last = 0;
         end
      end else if (m_pad) begin
         m_part.push_back(8'h00);
         if (m_part.size() == 16) close_block(1, fl);
         else m_pend |= fl;
      end else if (popped) begin
         m_part.push_back(head);
         if (m_part.size() == 16) close_block(0, 0);
         else m_pend |= fl;
      end else if (m_pend && m_part.size() > 0) begin
         m_pad = 1;
      end else begin
         m_pend = fl;
      end
   endfunction

   // Registered outputs against the model, every cycle
   always @(negedge clk) begin
      chk("valid", 128'(block_valid), 128'(m_pres));
      chk("last", 128'(block_last), 128'(m_pres && m_last));
      chk("held", 128'(bytes_held), m_pres ? 128'd16 : 128'(m_part.size()));
      if (m_pres) chk("data", block_data, m_blk);
   end

   task automatic step(input bit fl, input bit rdy, input bit rn);
      bit exp_pop, pop;
      logic [7:0] head;
      flush = fl;
      block_ready = rdy;
      #1;
      n_rst = rn;
      exp_pop = !m_pres && !m_pad && (fq.size() > 0);
      head = (fq.size() > 0) ? fq[0] : 8'h00;
      pop = fifo_r_enable;
      if (rn) chk("r_enable", 128'(pop), 128'(exp_pop));
      @(posedge clk);
      #1;
      if (rn && pop && fq.size() > 0) void'(fq.pop_front());
      fifo_refresh();
      model_update(fl, rdy, exp_pop, head);
      flush = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_valid(input int max, input bit rdy, output int n);
      n = 0;
      while (n < max && !block_valid) begin
         step(0, rdy, 1);
         n++;
      end
      if (!block_valid) chk("valid_timeout", 128'(block_valid), 128'd1);
   endtask

   int n, seen;

   initial begin
      @(negedge clk);
      repeat (3) step(0, 1, 0);
      chk("rst_valid", 128'(block_valid), 128'd0);
      chk("rst_held", 128'(bytes_held), 128'd0);
      step(0, 1, 1);

      // Basic block 00..0F
      for (int i = 0; i < 16; i++) push(8'(i));
      wait_valid(40, 1, n);
      chk("t2_latency", 128'(n), 128'd16);
      chk("t2_data", block_data, 128'h000102030405060708090A0B0C0D0E0F);
      chk("t2_last", 128'(block_last), 128'd0);
      step(0, 1, 1);
      chk("t2_one_cycle", 128'(block_valid), 128'd0);

      // Backpressure: 21 bytes, ready low
      for (int i = 0; i < 21; i++) push(8'(8'h20 + i));
      wait_valid(40, 0, n);
      repeat (10) step(0, 0, 1);
      chk("t3_valid_held", 128'(block_valid), 128'd1);
      chk("t3_data", block_data, 128'h202122232425262728292A2B2C2D2E2F);
      chk("t3_fifo_left", 128'(fq.size()), 128'd5);
      step(0, 1, 1);
      repeat (7) step(0, 1, 1);
      chk("t3_partial", 128'(bytes_held), 128'd5);
      step(1, 1, 1);
      wait_valid(40, 1, n);
      chk("t3_pad_data", block_data, 128'h30313233340000000000000000000000);
      step(0, 1, 1);

      // Flush raised right after loading a short packet
      for (int i = 0; i < 5; i++) push(8'(8'hA0 + i));
      step(1, 1, 1);
      wait_valid(40, 1, n);
      chk("t4_data", block_data, 128'hA0A1A2A3A4000000000000000000_0000);
      chk("t4_last", 128'(block_last), 128'd1);
      chk("t4_held", 128'(bytes_held), 128'd16);
      step(0, 1, 1);

      // Flush with nothing held: no block, flush not remembered
      step(1, 1, 1);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         step(0, 1, 1);
         if (block_valid) seen++;
      end
      chk("t5_no_block", 128'(seen), 128'd0);
      for (int i = 0; i < 3; i++) push(8'(8'h40 + i));
      repeat (10) step(0, 1, 1);
      chk("t5_no_pad", 128'(bytes_held), 128'd3);
      for (int i = 3; i < 16; i++) push(8'(8'h40 + i));
      wait_valid(40, 1, n);
      chk("t5_data", block_data, 128'h404142434445464748494A4B4C4D4E4F);
      chk("t5_last", 128'(block_last), 128'd0);
      step(0, 1, 1);

      // Reset after 7 pops; stale bytes must not leak
      for (int i = 0; i < 16; i++) push(8'(8'h50 + i));
      step(1, 1, 1);
      repeat (6) step(0, 1, 1);
      chk("t6_pre_held", 128'(bytes_held), 128'd7);
      fq.delete();
      fifo_refresh();
      step(0, 1, 0);
      chk("t1_valid", 128'(block_valid), 128'd0);
      chk("t1_data", block_data, 128'd0);
      chk("t1_last", 128'(block_last), 128'd0);
      chk("t1_held", 128'(bytes_held), 128'd0);
      step(0, 1, 1);
      for (int i = 0; i < 16; i++) push(8'(8'h10 + i));
      wait_valid(40, 1, n);
      chk("t6_data", block_data, 128'h101112131415161718191A1B1C1D1E1F);
      chk("t6_last", 128'(block_last), 128'd0);
      step(0, 1, 1);
      repeat (3) step(0, 1, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, failures so far %0d", failures);
      $fatal(1, "timeout");
   end

endmodule
